// File: rtl/pipe_adapter_pkg.sv
// Shared helpers and default widths for the pipeline latency adapter.
// Imported by sync_fifo and pipe_latency_adapter.
package pipe_adapter_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LATENCY    = 2;
   localparam int DEF_FIFO_DEPTH = 4;

   // Pointer width for a buffer of n entries, never below one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

   // Number of set bits; callers zero-extend narrower vectors.
   function automatic logic [31:0] popcount(input logic [31:0] v);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {31'b0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO; head reads 0 when empty.
// Pointers wrap naturally, so DEPTH must be a power of two.
module sync_fifo
   import pipe_adapter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   localparam int AW    = clog2_min1(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage write; contents are meaningless until counted in.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pipe_latency_adapter.sv
// Valid/ready wrapper around a fixed-latency handshake-free pipeline.
// Define PIPE_ADAPTER_PERF_EN to add the stall_cycles counter port.
module pipe_latency_adapter
   import pipe_adapter_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] pipe_a,
   output logic [DATA_W-1:0] pipe_b,
   input  logic [DATA_W-1:0] pipe_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_c
`ifdef PIPE_ADAPTER_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int AW = clog2_min1(FIFO_DEPTH);

   if (LATENCY < 1) begin : g_bad_lat
      $error("LATENCY must be at least 1");
   end
   if (FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least LATENCY+1");
   end
   if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
      $error("FIFO_DEPTH must be a power of two");
   end

   logic [LATENCY-1:0] vld_sr;
   logic [AW:0]        fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fire;
   logic               push;
   logic               pop;
   logic [31:0]        committed;

   assign pipe_a    = in_a;
   assign pipe_b    = in_b;
   assign committed = 32'(fifo_count) + popcount(32'(vld_sr));
   assign in_ready  = !rst && (committed < 32'(FIFO_DEPTH));
   assign fire      = in_valid && in_ready;
   assign push      = vld_sr[LATENCY-1];
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;

   // Track which pipeline slots carry a live result.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= fire;
         for (int i = 1; i < LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pipe_c),
      .head  (out_c),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Credits reserve a slot for every in-flight result.
   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst) !(push && fifo_full)
   );

`ifdef PIPE_ADAPTER_PERF_EN
   // Count cycles where upstream waits on credit; saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (in_valid && !in_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_latency_adapter.sv
// Directed bench for pipe_latency_adapter with a 2-stage adder model.
// Inputs change 1ns after posedge; outputs are checked 2ns after.
module tb_pipe_latency_adapter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] pipe_a;
   logic [31:0] pipe_b;
   logic [31:0] pipe_c = '0;
   logic [31:0] out_c;
   logic        in_ready;
   logic        out_valid;
`ifdef PIPE_ADAPTER_PERF_EN
   logic [31:0] stall_cycles;
`endif
   logic [31:0] p1 = '0;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_latency_adapter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .pipe_a    (pipe_a),
      .pipe_b    (pipe_b),
      .pipe_c    (pipe_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c)
`ifdef PIPE_ADAPTER_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Registered add32 pipeline, two edges deep.
   always @(posedge clk) begin
      p1     <= pipe_a + pipe_b;
      pipe_c <= p1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fires;
      logic [31:0] e;
      bit found;

      // Reset, then a single operation.
      rst = 1'b1;
      out_ready = 1'b1;
      tick;
      tick;
      settle;
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_c", out_c, 32'd0);
      tick;
      rst = 1'b0;
      in_valid = 1'b1;
      in_a = 32'h5;
      in_b = 32'h7;
      settle;
      check("c1_in_ready", {31'b0, in_ready}, 32'd1);
      tick;
      in_valid = 1'b0;
      settle;
      check("c2_out_valid", {31'b0, out_valid}, 32'd0);
      tick;
      settle;
      check("c3_out_valid", {31'b0, out_valid}, 32'd0);
      tick;
      settle;
      check("c4_out_valid", {31'b0, out_valid}, 32'd1);
      check("c4_out_c", out_c, 32'h0000000C);
      tick;
      settle;
      check("c5_out_valid", {31'b0, out_valid}, 32'd0);

      // Streaming: 16 back-to-back ops.
      for (int k = 0; k < 20; k++) begin
         tick;
         in_valid = (k < 16);
         in_a = 32'(k + 1);
         in_b = 32'hFFFFFFF0;
         settle;
         if (k < 16) check("strm_rdy", {31'b0, in_ready}, 32'd1);
         if (k >= 3 && k < 19) begin
            e = 32'(k - 2) + 32'hFFFFFFF0;
            check("strm_vld", {31'b0, out_valid}, 32'd1);
            check("strm_c", out_c, e);
         end
         if (k == 19) check("strm_end", {31'b0, out_valid}, 32'd0);
      end

      // Backpressure: fill, then drain.
      fires = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick;
         in_valid = 1'b1;
         in_a = 32'h100 + 32'(fires);
         in_b = 32'h0;
         settle;
         if (in_ready) fires++;
      end
      check("bp_fires", 32'(fires), 32'd4);
      check("bp_rdy_low", {31'b0, in_ready}, 32'd0);
      tick;
      in_valid = 1'b0;
      out_ready = 1'b1;
      settle;
      check("bp_rdy_pop0", {31'b0, in_ready}, 32'd0);
      check("bp_c0", out_c, 32'h100);
      for (int j = 1; j < 4; j++) begin
         tick;
         settle;
         if (j == 1) check("bp_rdy_back", {31'b0, in_ready}, 32'd1);
         check("bp_vld", {31'b0, out_valid}, 32'd1);
         check("bp_c", out_c, 32'h100 + 32'(j));
      end
      tick;
      settle;
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      // Simultaneous push and pop at count 2.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         in_valid = 1'b1;
         in_a = 32'h11 * 32'(k + 1);
         in_b = 32'h0;
         settle;
      end
      tick;
      in_valid = 1'b0;
      settle;
      check("pp_c3_vld", {31'b0, out_valid}, 32'd1);
      check("pp_c3_c", out_c, 32'h11);
      tick;
      out_ready = 1'b1;
      settle;
      check("pp_c4_c", out_c, 32'h11);
      tick;
      settle;
      check("pp_c5_c", out_c, 32'h22);
      tick;
      settle;
      check("pp_c6_c", out_c, 32'h33);
      tick;
      settle;
      check("pp_c7_vld", {31'b0, out_valid}, 32'd0);

      // Reset while two results are in flight.
      tick;
      in_valid = 1'b1;
      in_a = 32'hAA;
      in_b = 32'h0;
      tick;
      in_a = 32'hBB;
      tick;
      in_valid = 1'b0;
      rst = 1'b1;
      settle;
      check("mr_rst_rdy", {31'b0, in_ready}, 32'd0);
      tick;
      rst = 1'b0;
      in_valid = 1'b1;
      in_a = 32'h1;
      in_b = 32'h1;
      settle;
      check("mr_c3_vld", {31'b0, out_valid}, 32'd0);
      check("mr_c3_rdy", {31'b0, in_ready}, 32'd1);
      tick;
      in_valid = 1'b0;
      settle;
      check("mr_c4_vld", {31'b0, out_valid}, 32'd0);
      tick;
      settle;
      check("mr_c5_vld", {31'b0, out_valid}, 32'd0);
      tick;
      settle;
      check("mr_c6_vld", {31'b0, out_valid}, 32'd1);
      check("mr_c6_c", out_c, 32'h2);
      tick;
      settle;
      check("mr_c7_vld", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_ADAPTER_PERF_EN
      // Stall counter: 10 blocked cycles, then reset.
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      out_ready = 1'b0;
      settle;
      check("pf_rst_cnt", stall_cycles, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick;
         in_valid = 1'b1;
         in_a = 32'(k);
         in_b = 32'h0;
         settle;
         if (!in_ready) begin
            found = 1'b1;
            break;
         end
      end
      check("pf_filled", {31'b0, found}, 32'd1);
      for (int j = 0; j < 9; j++) begin
         tick;
         settle;
      end
      tick;
      in_valid = 1'b0;
      settle;
      check("pf_stall10", stall_cycles, 32'd10);
      rst = 1'b1;
      tick;
      settle;
      check("pf_stall_rst", stall_cycles, 32'd0);
      rst = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
